// File: rtl/blink_period_meter_pkg.sv
// Shared types and constants for the blink period meter.
package blink_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    STUCK   = 2'd3
  } state_t;

  localparam int SYNC_STAGES = 2;
  localparam int EDGE_CNT_W  = 16;

endpackage

// File: rtl/blink_period_meter_if.sv
// Signal bundle between the monitored source and the period meter.
interface blink_period_meter_if #(
  parameter int CNT_W = 33
);
  import blink_meter_pkg::*;

  logic                  din;
  logic [CNT_W-1:0]      half_period;
  logic                  period_valid;
  logic                  locked;
  logic                  stuck;
  logic [EDGE_CNT_W-1:0] edge_count;

  // Source / observer side: drives din, reads the measurement results.
  modport master (
    output din,
    input  half_period, period_valid, locked, stuck, edge_count
  );

  // Meter side: samples din, produces the measurement results.
  modport slave (
    input  din,
    output half_period, period_valid, locked, stuck, edge_count
  );

endinterface

// File: rtl/blink_period_meter_sync_edge_detect.sv
// Synchronizes an asynchronous 1-bit input and flags every transition.
module sync_edge_detect
  import blink_meter_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic edge_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   delayed;

  // Metastability chain followed by one delayed copy for edge comparison.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      delayed <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
      delayed <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising and falling transitions both count.
  assign edge_pulse = sync_q[SYNC_STAGES-1] ^ delayed;

endmodule

// File: rtl/blink_period_meter.sv
// Measures the half-period of a toggling input and reports lock / stuck status.
module blink_period_meter
  import blink_meter_pkg::*;
#(
  parameter int CNT_W       = 33,
  parameter int EXPECT_HALF = 6,
  parameter int TOL         = 1,
  parameter int LOCK_COUNT  = 4,
  parameter int MAX_HALF    = 64
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  blink_period_meter_if.slave bus
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_COUNT);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
  localparam logic [EDGE_CNT_W-1:0] EC_ONE = EDGE_CNT_W'(1);

  // Absolute deviation from the expected half-period, one bit wider and signed so
  // the subtraction cannot wrap.
  function automatic logic is_match(input logic [CNT_W-1:0] m);
    logic signed [CNT_W:0] diff;
    logic signed [CNT_W:0] mag;
    diff = $signed({1'b0, m}) - $signed((CNT_W+1)'(EXPECT_HALF));
    mag  = diff[CNT_W] ? -diff : diff;
    return (mag <= $signed((CNT_W+1)'(TOL)));
  endfunction

  logic                  edge_pulse;
  state_t                state, state_n;
  logic [CNT_W-1:0]      cnt, cnt_n, measured;
  logic [CNT_W-1:0]      half_period, half_period_n;
  logic [RUN_W-1:0]      match_run, match_run_n;
  logic                  period_valid, period_valid_n;
  logic                  locked, stuck;
  logic [EDGE_CNT_W-1:0] edge_count;
  logic                  hit, timeout;

  sync_edge_detect u_sync (
    .clk        (CLOCK_50),
    .rst        (reset),
    .din        (bus.din),
    .edge_pulse (edge_pulse)
  );

  // Interval counter: measures the current gap, saturating at the timeout value.
  always_comb begin
    measured = cnt + CNT_ONE;
    hit      = is_match(measured);
    timeout  = (cnt == CNT_MAX) && !edge_pulse;
    if (edge_pulse)          cnt_n = '0;
    else if (cnt == CNT_MAX) cnt_n = cnt;
    else                     cnt_n = cnt + CNT_ONE;
  end

  // Next-state and next-output decode; an edge always takes priority over timeout.
  always_comb begin
    state_n        = state;
    match_run_n    = match_run;
    half_period_n  = half_period;
    period_valid_n = 1'b0;
    if (edge_pulse) begin
      case (state)
        IDLE, STUCK: begin
          state_n     = MEASURE;
          match_run_n = '0;
        end
        MEASURE: begin
          period_valid_n = 1'b1;
          half_period_n  = measured;
          if (hit) begin
            match_run_n = match_run + RUN_ONE;
            if (match_run + RUN_ONE == RUN_LOCK) state_n = LOCKED;
          end else begin
            match_run_n = '0;
          end
        end
        LOCKED: begin
          period_valid_n = 1'b1;
          half_period_n  = measured;
          if (!hit) begin
            state_n     = MEASURE;
            match_run_n = '0;
          end
        end
        default: state_n = IDLE;
      endcase
    end else if (timeout) begin
      state_n     = STUCK;
      match_run_n = '0;
    end
  end

  // Control state: FSM, interval counter and match run length.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      match_run <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      match_run <= match_run_n;
    end
  end

  // Registered outputs so status lines change only on clock edges.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      stuck        <= 1'b0;
      edge_count   <= '0;
    end else begin
      half_period  <= half_period_n;
      period_valid <= period_valid_n;
      locked       <= (state_n == LOCKED);
      stuck        <= (state_n == STUCK);
      if (edge_pulse) edge_count <= edge_count + EC_ONE;
    end
  end

  assign bus.half_period  = half_period;
  assign bus.period_valid = period_valid;
  assign bus.locked       = locked;
  assign bus.stuck        = stuck;
  assign bus.edge_count   = edge_count;

endmodule

// File: tb/tb_blink_period_meter.sv
// Directed, table-driven bench for blink_period_meter.
module tb_blink_period_meter;
  import blink_meter_pkg::*;

  localparam int CNT_W = 33;

  typedef struct {
    int     gap;
    bit     valid;
    longint hp;
    bit     locked;
    bit     stuck;
    int     ec;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  vec_t vecs[34];
  int   errors = 0;
  int   checks = 0;
  int   since  = 0;

  always #5 clk = ~clk;

  blink_period_meter_if #(.CNT_W(CNT_W)) bus ();

  blink_period_meter #(
    .CNT_W(CNT_W), .EXPECT_HALF(6), .TOL(1), .LOCK_COUNT(4), .MAX_HALF(64)
  ) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    since++;
  endtask

  task automatic check_all(input string tag, input bit v, input longint hp,
                           input bit lk, input bit st, input int ec);
    chk({tag, " period_valid"}, 64'(bus.period_valid), 64'(v));
    chk({tag, " half_period"},  64'(bus.half_period),  64'(hp));
    chk({tag, " locked"},       64'(bus.locked),       64'(lk));
    chk({tag, " stuck"},        64'(bus.stuck),        64'(st));
    chk({tag, " edge_count"},   64'(bus.edge_count),   64'(ec));
  endtask

  // Wait out the gap since the previous toggle, toggle, then check the update
  // three cycles later and that the valid pulse lasts a single cycle.
  task automatic apply(input int i);
    string tag;
    tag = $sformatf("v%0d", i);
    while (since < vecs[i].gap) tick();
    bus.din = ~bus.din;
    since   = 0;
    repeat (3) tick();
    check_all(tag, vecs[i].valid, vecs[i].hp, vecs[i].locked, vecs[i].stuck, vecs[i].ec);
    tick();
    chk({tag, " valid_one_cycle"}, 64'(bus.period_valid), 64'd0);
  endtask

  initial begin
    vecs[0]  = '{6, 1'b0, 0, 1'b0, 1'b0, 1};
    vecs[1]  = '{6, 1'b1, 6, 1'b0, 1'b0, 2};
    vecs[2]  = '{6, 1'b1, 6, 1'b0, 1'b0, 3};
    vecs[3]  = '{6, 1'b1, 6, 1'b0, 1'b0, 4};
    vecs[4]  = '{6, 1'b1, 6, 1'b1, 1'b0, 5};
    vecs[5]  = '{7, 1'b1, 7, 1'b1, 1'b0, 6};
    vecs[6]  = '{7, 1'b1, 7, 1'b1, 1'b0, 7};
    vecs[7]  = '{8, 1'b1, 8, 1'b0, 1'b0, 8};
    vecs[8]  = '{8, 1'b1, 8, 1'b0, 1'b0, 9};
    vecs[9]  = '{7, 1'b1, 7, 1'b0, 1'b0, 10};
    vecs[10] = '{7, 1'b1, 7, 1'b0, 1'b0, 11};
    vecs[11] = '{7, 1'b1, 7, 1'b0, 1'b0, 12};
    vecs[12] = '{7, 1'b1, 7, 1'b1, 1'b0, 13};
    vecs[13] = '{9, 1'b1, 9, 1'b0, 1'b0, 14};
    vecs[14] = '{6, 1'b1, 6, 1'b0, 1'b0, 15};
    vecs[15] = '{6, 1'b1, 6, 1'b0, 1'b0, 16};
    vecs[16] = '{6, 1'b1, 6, 1'b0, 1'b0, 17};
    vecs[17] = '{6, 1'b1, 6, 1'b1, 1'b0, 18};
    vecs[18] = '{5, 1'b1, 5, 1'b1, 1'b0, 19};
    vecs[19] = '{4, 1'b1, 4, 1'b0, 1'b0, 20};
    vecs[20] = '{6, 1'b1, 6, 1'b0, 1'b0, 21};
    vecs[21] = '{6, 1'b1, 6, 1'b0, 1'b0, 22};
    vecs[22] = '{6, 1'b1, 6, 1'b0, 1'b0, 23};
    vecs[23] = '{6, 1'b1, 6, 1'b1, 1'b0, 24};
    vecs[24] = '{100, 1'b0, 6, 1'b0, 1'b0, 25};
    vecs[25] = '{6, 1'b1, 6, 1'b0, 1'b0, 26};
    vecs[26] = '{6, 1'b1, 6, 1'b0, 1'b0, 27};
    vecs[27] = '{6, 1'b1, 6, 1'b0, 1'b0, 28};
    vecs[28] = '{6, 1'b1, 6, 1'b1, 1'b0, 29};
    vecs[29] = '{64, 1'b1, 64, 1'b0, 1'b0, 30};
    vecs[30] = '{6, 1'b1, 6, 1'b0, 1'b0, 31};
    vecs[31] = '{6, 1'b1, 6, 1'b0, 1'b0, 32};
    vecs[32] = '{6, 1'b1, 6, 1'b0, 1'b0, 33};
    vecs[33] = '{6, 1'b1, 6, 1'b1, 1'b0, 34};

    reset   = 1'b1;
    bus.din = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    check_all("reset", 1'b0, 0, 1'b0, 1'b0, 0);
    reset = 1'b0;
    since = 0;

    // First lock at 6, tolerance 7, mismatch 8, relock at 7, unlock at 9,
    // tolerance edges 5 and 4.
    for (int i = 0; i < 24; i++) apply(i);

    // Hold din: stuck appears exactly 64 cycles after the last edge update.
    while (since < 66) tick();
    chk("pre_stuck stuck", 64'(bus.stuck), 64'd0);
    chk("pre_stuck locked", 64'(bus.locked), 64'd1);
    tick();
    chk("stuck stuck", 64'(bus.stuck), 64'd1);
    chk("stuck locked", 64'(bus.locked), 64'd0);
    chk("stuck period_valid", 64'(bus.period_valid), 64'd0);

    // Recovery from stuck, relock, then an interval of exactly the timeout length.
    for (int i = 24; i < 34; i++) apply(i);

    // Asynchronous reset mid-lock, between clock edges.
    #3;
    reset = 1'b1;
    #1;
    check_all("async_reset", 1'b0, 0, 1'b0, 1'b0, 0);
    bus.din = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #4;
    reset = 1'b0;
    since = 0;
    check_all("post_reset", 1'b0, 0, 1'b0, 1'b0, 0);

    for (int i = 0; i < 5; i++) apply(i);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
